serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial multi-bit adder built around a one-bit adder cell (sum = x^y^cy, carry = majority) and a carry flip-flop.
- Downstream consumer of our combinational adder cells: chains the cell's sum and carry over time instead of over space.
- Loads two WIDTH-bit operands and processes them LSB-first, one bit per clock.
- Presents the registered sum and carry-out with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin an addition; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- busy  output  1  high in RUN and DONE states
- done  output  1  one-cycle pulse; s and cout valid and newly updated
- s  output  WIDTH  registered sum; holds until next completion
- cout  output  1  registered final carry; holds until next completion

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset value of every output: busy=0, done=0, s=0, cout=0.
- Reset clears all internal state: state=IDLE, shift registers=0, carry flop=0, bit counter=0.

State machine (3 states: IDLE, RUN, DONE):
- IDLE:
  - start=1 at a rising edge (edge k) loads A_sh<=a and B_sh<=b.
  - Same edge clears the carry flop and sets the counter to 0.
  - Next state is RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each edge computes bit = A_sh[0]^B_sh[0]^cy and cy <= majority(A_sh[0], B_sh[0], cy).
  - bit is shifted into the MSB of the internal sum shift register.
  - A_sh and B_sh shift right by one; counter increments.
  - On the edge where the counter equals WIDTH-1 (edge k+WIDTH): the final bit is shifted in, s <= the completed sum, cout <= final carry, next state is DONE.
- DONE:
  - done=1 for exactly one cycle (the cycle after edge k+WIDTH).
  - Next edge returns unconditionally to IDLE.

Timing and handshake rules:
- Latency: done asserted WIDTH+1 cycles after the cycle in which start was sampled.
- Earliest back-to-back start is the cycle after DONE, i.e. throughput of one result per WIDTH+2 cycles.
- start is ignored in RUN and DONE. No queuing: a request that is not accepted is lost.
- a and b are don't-care outside the accepting edge. Changing them mid-RUN has no effect.

Boundary conditions:
- s and cout do not change during RUN; the previous result stays visible until the new done.
- Overflow: cout=1 and s holds the low WIDTH bits, i.e. (a+b) mod 2^WIDTH.
- Counter width is clog2(WIDTH). WIDTH a power of two must not wrap the counter early.
- Reset asserted mid-RUN aborts immediately: no done pulse, and s/cout clear to 0.
- Reset released with start=1 already high: start is accepted on the first rising edge after release.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN
- Defined:
  - Extra port sub (input, 1), sampled with start.
  - sub=1 stores ~b into B_sh and initialises the carry flop to 1, giving s = a - b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b); cout=0 means borrow.
  - sub=0 behaves exactly as addition.
- Undefined:
  - No sub port; carry always initialises to 0; addition only.

Test Plan (WIDTH=8):
- Basic add: reset, then start with a=0x00, b=0x00 -> done pulse 9 cycles after the start cycle; s=0x00, cout=0; busy high for 9 cycles.
- Carry chain: a=0xA5, b=0x5A -> s=0xFF, cout=0. Then a=0xFF, b=0x01 -> s=0x00, cout=1. The second result's carry ripples through all 8 bit positions.
- Start while busy:
  - a=0x12, b=0x34 accepted.
  - Pulse start with a=0xFF, b=0xFF at cycle 3 of RUN and again in the DONE cycle.
  - Expected: single done; s=0x46, cout=0.
  - A start in the following IDLE cycle is accepted.
- Reset mid-operation:
  - Complete a=0x0F, b=0x01 -> s=0x10.
  - Start a=0x80, b=0x80; assert rst_n=0 at RUN cycle 4.
  - Expected: busy, done, s and cout go to 0 immediately, with no done pulse.
  - After release, a=0x80, b=0x80 -> s=0x00, cout=1.
- Back-to-back plus hold:
  - Three operations issued at the earliest allowed cycles.
  - s holds each result unchanged through the next RUN and updates only with the done pulse.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x05, b=0x07 -> s=0xFE, cout=0.
  - sub=1, a=0x07, b=0x05 -> s=0x02, cout=1.
  - sub=0, a=0x07, b=0x05 -> s=0x0C, cout=0.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder.
// Operands are loaded on start and consumed LSB-first, one bit per clock,
// through a single full-adder cell whose carry is held in a flip-flop.
// The sum and carry-out are registered and announced with a one-cycle done pulse.
// Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a - b (B is inverted on load and the carry starts at 1).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] aSh_q;
    logic [WIDTH-1:0] bSh_q;
    logic [WIDTH-2:0] sumSh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;

    logic             sumBit_d;
    logic             carry_d;
    logic [WIDTH-1:0] sumNext_d;
    logic [WIDTH-1:0] bLoad_d;
    logic             carryInit_d;

    // One-bit adder cell on the current LSBs plus the partial sum with the new bit on top.
    always_comb begin
        sumBit_d  = aSh_q[0] ^ bSh_q[0] ^ carry_q;
        carry_d   = (aSh_q[0] & bSh_q[0]) | (aSh_q[0] & carry_q) | (bSh_q[0] & carry_q);
        sumNext_d = {sumBit_d, sumSh_q};
    end

    // Operand B and initial carry as loaded on the accepting edge.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        bLoad_d     = sub ? ~b : b;
        carryInit_d = sub;
`else
        bLoad_d     = b;
        carryInit_d = 1'b0;
`endif
    end

    // Control FSM and datapath: load in IDLE, shift one bit per clock in RUN, pulse done in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            sumSh_q <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        aSh_q   <= a;
                        bSh_q   <= bLoad_d;
                        carry_q <= carryInit_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    aSh_q   <= {1'b0, aSh_q[WIDTH-1:1]};
                    bSh_q   <= {1'b0, bSh_q[WIDTH-1:1]};
                    sumSh_q <= sumNext_d[WIDTH-1:1];
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        s_q     <= sumNext_d;
                        cout_q  <= carry_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8).
// A driver issues operations at times it knows the adder is idle and pushes
// the arithmetic result plus the accepting cycle into a queue; a monitor
// checks busy, done timing, results and result hold every cycle.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sub   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    typedef struct {
        int               acc;
        logic [WIDTH-1:0] s;
        logic             c;
    } exp_t;

    exp_t             q[$];
    int               cyc     = 0;
    int               freeAt  = 0;
    int               errors  = 0;
    int               checks  = 0;
    logic [WIDTH-1:0] lastS   = '0;
    logic             lastC   = 1'b0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: actual=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    // Reference: plain modular arithmetic on the operands.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic sv, input int acc);
        exp_t e;
        longint unsigned x, y, m, t;
        x = longint'(av);
        y = longint'(bv);
        m = 64'd1 << WIDTH;
        e.acc = acc;
        if (sv) begin
            t   = (x + m - y) % m;
            e.s = t[WIDTH-1:0];
            e.c = (x >= y);
        end else begin
            t   = x + y;
            e.s = t[WIDTH-1:0];
            e.c = (t >= m);
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic sv);
        int   acc;
        logic sEff;
`ifdef SERIAL_ADDER_SUB_EN
        sEff = sv;
`else
        sEff = 1'b0;
`endif
        @(negedge clk);
        while (cyc + 1 < freeAt) @(negedge clk);
        acc   = cyc + 1;
        start = 1'b1;
        a     = av;
        b     = bv;
        sub   = sEff;
        q.push_back(model(av, bv, sEff, acc));
        freeAt = acc + WIDTH + 2;
        @(negedge clk);
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        sub   = 1'(($urandom));
    endtask

    // Raise start for one edge while the adder is known to be busy; it must be ignored.
    task automatic pokeStart(input int edgeNum);
        @(negedge clk);
        while (cyc + 1 < edgeNum) @(negedge clk);
        start = 1'b1;
        a     = '1;
        b     = '1;
        @(negedge clk);
        start = 1'b0;
    endtask

    always @(posedge clk) begin
        logic front, expBusy, expDone;
        cyc++;
        #3;
        front   = (q.size() > 0);
        expBusy = front && (cyc >= q[0].acc);
        expDone = front && (cyc == q[0].acc + WIDTH);
        checkOutput("busy", 64'(busy), 64'(expBusy));
        checkOutput("done", 64'(done), 64'(expDone));
        if (expDone) begin
            checkOutput("sum", 64'(s), 64'(q[0].s));
            checkOutput("cout", 64'(cout), 64'(q[0].c));
            lastS = q[0].s;
            lastC = q[0].c;
            void'(q.pop_front());
        end else begin
            checkOutput("sHold", 64'(s), 64'(lastS));
            checkOutput("coutHold", 64'(cout), 64'(lastC));
        end
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'h00, 8'h00, 1'b0);
        applyStimulus(8'hA5, 8'h5A, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0);

        applyStimulus(8'h12, 8'h34, 1'b0);
        n = freeAt - WIDTH - 2;
        pokeStart(n + 3);
        pokeStart(n + WIDTH + 1);
        applyStimulus(8'h01, 8'h02, 1'b0);

        applyStimulus(8'h0F, 8'h01, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0);
        n = freeAt - WIDTH - 2;
        @(negedge clk);
        while (cyc < n + 4) @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        lastS  = '0;
        lastC  = 1'b0;
        freeAt = 0;
        #1;
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstDone", 64'(done), 64'd0);
        checkOutput("rstSum", 64'(s), 64'd0);
        checkOutput("rstCout", 64'(cout), 64'd0);
        @(negedge clk);
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h80;
        sub   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(model(8'h80, 8'h80, 1'b0, cyc + 1));
        freeAt = cyc + 1 + WIDTH + 2;
        @(negedge clk);
        start = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        applyStimulus(8'h05, 8'h07, 1'b1);
        applyStimulus(8'h07, 8'h05, 1'b1);
        applyStimulus(8'h07, 8'h05, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'(($urandom)));
            if ($urandom_range(0, 1) == 1)
                pokeStart(freeAt - 1 - int'($urandom_range(0, WIDTH - 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        checkOutput("drain", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
